// File: rtl/instruction_fetch.sv
// Fetch unit: PC, redirect, and 2-entry skid buffer toward decode.
// Optional halt-on-all-ones behaviour under `FETCH_HALT_EN.
module instruction_fetch #(
  parameter int PC_WIDTH = 8,
  parameter int INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [PC_WIDTH-1:0]    pc,
  input  logic [INSTR_WIDTH-1:0] instruct,
  input  logic                   branch_valid,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]    out_pc
);

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH} state_t;
`endif

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(4);

  state_t                 state;
  logic                   tail_valid;
  logic [INSTR_WIDTH-1:0] tail_instr;
  logic [PC_WIDTH-1:0]    tail_pc;

  logic                pop;
  logic                full;
  logic                push;
  logic [PC_WIDTH-1:0] target;
  logic                unused_bits;

  assign pop    = out_valid & out_ready;
  assign full   = out_valid & tail_valid;
  assign push   = (state == FETCH) & ~branch_valid
                & (~full | pop);
  assign target = {branch_target[PC_WIDTH-1:2], 2'b00};
  assign unused_bits = ^branch_target[1:0];

  // Head lives in the out_* registers; tail is the second slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_pc     <= '0;
      tail_valid <= 1'b0;
      tail_instr <= '0;
      tail_pc    <= '0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        default: begin
          if (branch_valid) begin
            out_valid  <= 1'b0;
            tail_valid <= 1'b0;
            pc         <= target;
            state      <= FETCH;
          end else begin
            if (push) begin
              pc <= pc + STEP;
`ifdef FETCH_HALT_EN
              if (instruct == {INSTR_WIDTH{1'b1}})
                state <= HALT;
`endif
            end
            if (pop) begin
              if (tail_valid) begin
                out_instr  <= tail_instr;
                out_pc     <= tail_pc;
                tail_valid <= push;
                if (push) begin
                  tail_instr <= instruct;
                  tail_pc    <= pc;
                end
              end else begin
                out_valid <= push;
                if (push) begin
                  out_instr <= instruct;
                  out_pc    <= pc;
                end
              end
            end else if (push) begin
              if (!out_valid) begin
                out_valid <= 1'b1;
                out_instr <= instruct;
                out_pc    <= pc;
              end else begin
                tail_valid <= 1'b1;
                tail_instr <= instruct;
                tail_pc    <= pc;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch.
// Directed scenarios; a negedge monitor checks every accepted word.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  pc;
  logic [31:0] instruct;
  logic        branch_valid = 1'b0;
  logic [7:0]  branch_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;

  logic [31:0] mem [64];
  assign instruct = mem[pc[7:2]];

  instruction_fetch dut (
    .clk(clk),
    .rst(rst),
    .pc(pc),
    .instruct(instruct),
    .branch_valid(branch_valid),
    .branch_target(branch_target),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] ins;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic want(input logic [7:0] p, input logic [31:0] i);
    q.push_back('{pc: p, ins: i});
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_word", {24'h0, out_pc}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_pc", {24'h0, out_pc}, {24'h0, e.pc});
        chk("sb_instr", out_instr, e.ins);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Asserted between edges; values must already be reset 1ns later.
  task automatic do_reset();
    chk("drained", q.size(), 0);
    rst = 1'b0;
    #1;
    chk("rst_valid", {31'h0, out_valid}, 0);
    chk("rst_pc", {24'h0, pc}, 0);
    chk("rst_out_pc", {24'h0, out_pc}, 0);
    chk("rst_out_instr", out_instr, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic s_start();
    out_ready = 1'b1;
    want(8'h00, 32'h1111_1111);
    want(8'h04, 32'h2222_2222);
    want(8'h08, 32'h3333_3333);
    want(8'h0C, 32'h4444_4444);
    @(posedge clk);
    @(negedge clk);
    chk("start_idle_valid", {31'h0, out_valid}, 0);
    @(posedge clk);
    @(negedge clk);
    chk("start_first_valid", {31'h0, out_valid}, 1);
    chk("start_first_pc", {24'h0, out_pc}, 0);
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333;
    mem[3] = 32'h4444_4444;
    #2;
    do_reset();
    s_start();

    out_ready = 1'b0;
    do_reset();
    cyc(7);
    chk("bp_pc_hold", {24'h0, pc}, 32'h08);
    chk("bp_valid", {31'h0, out_valid}, 1);
    want(8'h00, 32'h1111_1111);
    want(8'h04, 32'h2222_2222);
    want(8'h08, 32'h3333_3333);
    out_ready = 1'b1;
    cyc(3);
    out_ready = 1'b0;

    branch_valid = 1'b1;
    branch_target = 8'h43;
    cyc(1);
    branch_valid = 1'b0;
    out_ready = 1'b1;
    chk("br_pc", {24'h0, pc}, 32'h40);
    want(8'h40, 32'hC0DE_0010);
    @(negedge clk);
    chk("br_bubble", {31'h0, out_valid}, 0);
    @(posedge clk);
    @(negedge clk);
    chk("br_target_pc", {24'h0, out_pc}, 32'h40);
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    branch_valid = 1'b1;
    branch_target = 8'hFC;
    cyc(1);
    branch_valid = 1'b0;
    out_ready = 1'b1;
    want(8'hFC, 32'hC0DE_003F);
    want(8'h00, 32'h1111_1111);
    want(8'h04, 32'h2222_2222);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("wrap_pc", {24'h0, out_pc}, 32'h00);
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;

    cyc(2);
    #3;
    do_reset();
    s_start();

`ifdef FETCH_HALT_EN
    mem[2] = 32'hFFFF_FFFF;
    out_ready = 1'b0;
    do_reset();
    out_ready = 1'b1;
    want(8'h00, 32'h1111_1111);
    want(8'h04, 32'h2222_2222);
    want(8'h08, 32'hFFFF_FFFF);
    cyc(6);
    chk("halt_valid", {31'h0, out_valid}, 0);
    chk("halt_pc", {24'h0, pc}, 32'h0C);
    branch_valid = 1'b1;
    branch_target = 8'h00;
    cyc(1);
    branch_valid = 1'b0;
    want(8'h00, 32'h1111_1111);
    @(posedge clk);
    @(negedge clk);
    chk("halt_resume_pc", {24'h0, out_pc}, 32'h00);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    mem[2] = 32'h3333_3333;
`endif

    cyc(2);
    chk("final_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
